vip_sobel_edge_param: RTL and testbench
=======================================

Name: vip_sobel_edge_param

Overview:
- Parametrised streaming Sobel edge detector for the VIP chain; sits downstream of the RGB-to-Y converter and upstream of the binary/morphology stages.
- Builds its own 3x3 window from two internal line buffers.
- Computes the L1 gradient magnitude |Gx|+|Gy|, with no CORDIC or square root.
- Emits a binary edge bit and an optional grey magnitude. Threshold and mode are run-time configurable and latched per frame.

Parameters:
- DATA_W, 8: pixel bit width.
- IMG_W, 640: maximum pixels per line (line-buffer depth).
- COL_W, 10: column-counter/address width; must satisfy 2^COL_W >= IMG_W+1.
- DEFAULT_THRESHOLD, 35: threshold shadow value after reset.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  input frame sync, active high.
- per_frame_href  in  1  input line valid.
- per_frame_clken  in  1  input pixel strobe.
- per_img_y  in  DATA_W  input luminance.
- cfg_threshold  in  DATA_W+3  edge threshold, compared with >=.
- cfg_mode  in  1  0 = binary output, 1 = magnitude output.
- post_frame_vsync  out  1  vsync delayed 4 clk.
- post_frame_href  out  1  href delayed 4 clk.
- post_frame_clken  out  1  clken delayed 4 clk.
- post_img_bit  out  1  edge flag, gated by post_frame_href.
- post_img_y  out  DATA_W  mode 0: all bits = post_img_bit; mode 1: saturated magnitude. Gated to 0 when post_frame_href=0.
- line_overflow  out  1  sticky: a line exceeded IMG_W pixels in the current frame.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the only clock. All outputs, delay lines, counters, window and pipeline registers reset to 0. The threshold shadow resets to DEFAULT_THRESHOLD; the mode shadow resets to 0.
- Config latch: cfg_threshold and cfg_mode are copied into the shadows only on the rising edge of per_frame_vsync (detected by a registered compare). Mid-frame changes have no effect until the next frame.
- Counters:
  - col increments on clken while href=1 and clears on the falling edge of href.
  - row increments on the falling edge of href and clears on the rising edge of vsync.
  - col saturates at IMG_W.
- Line buffers: two RAMs of depth IMG_W, addressed by col, read-before-write on clken. They supply the rows r-1 and r-2 aligned with the current pixel.
- Window: 3 columns x 3 rows of registers, shifting on clken only. The current input pixel is the bottom-right element (p33).
- Pipeline: advances every clk. Stage timing relative to input sampled at edge t:
  - t+1: window valid.
  - t+2: column sums S_L = p11+2p21+p31, S_R = p13+2p23+p33; row sums S_T = p11+2p12+p13, S_B = p31+2p32+p33. Width DATA_W+2, unsigned.
  - t+3: |Gx| = |S_R-S_L|, |Gy| = |S_T-S_B|, each computed as a compare-then-subtract without signed wrap.
  - t+4: mag = |Gx|+|Gy| (DATA_W+3 bits); outputs registered.
- Fixed latency: 4 clk. All three sync signals pass through 4-stage shift registers.
- Border rule: an output is forced to 0 (bit=0, post_img_y=0) unless the corresponding input had row>=2 and 2<=col<IMG_W. The validity flag travels down the pipeline with the data.
- Edge decision: bit = (mag >= threshold shadow). With threshold 0, every valid interior pixel gives bit=1.
- Magnitude mode: post_img_y = min(mag, 2^DATA_W-1).
- Overflow:
  - Pixels arriving with col>=IMG_W are not written to RAM and produce output 0.
  - line_overflow sets on the first such pixel.
  - line_overflow clears on the vsync rising edge; if an overflowing pixel coincides with that edge, set wins.
- No clken during href: nothing shifts; the pipeline replays a stale value, but the output is masked by the delayed clken/href only for href. The sink must qualify with post_frame_clken.
- Reset mid-frame: output resumes correctly only from the next vsync rising edge. Row/col start from 0, so the first two rows after reset are borders.

Test Plan:
- Flat 8x8 frame, all pixels 0x80, IMG_W=16, threshold 35 -> post_img_bit=0 on all 64 pixels; post_frame_* equal the inputs delayed exactly 4 clk.
- 8x8 vertical step (cols 0-4 = 0, cols 5-7 = 100), threshold 35, mode 0 -> bit=1 only at rows 2-7, cols 5-6 (Gx=400), post_img_y=0xFF there; all other pixels 0.
- Same step with mode 1 latched at vsync -> post_img_y=255 (saturated from 400) at those pixels. Horizontal step 0->10 at row 4 gives Gy=40, post_img_y=40 at rows 4-5, cols 2-7.
- Step of amplitude 8 (Gx=32): frame 1 with threshold 35 -> no edges. Threshold changed to 32 mid-frame 1 -> still no edges in frame 1; edges at cols 5-6 in frame 2.
- IMG_W=16, lines of 20 pixels -> cols 16-19 output 0; line_overflow rises with the first col-16 pixel, holds through the frame, and clears at the next vsync rise.
- Assert rst_n low for 3 clk mid-line -> all outputs 0 immediately and the shadow threshold returns to 35. The next full frame gives results identical to the step test.

Source files
------------

// File: rtl/vip_sobel_edge_param.sv
// Streaming 3x3 Sobel edge detector: builds its window from two line buffers and
// emits an L1-magnitude edge bit or saturated grey magnitude, 4 clk after the input.
module vip_sobel_edge_param #(
  parameter int DATA_W            = 8,
  parameter int IMG_W             = 640,
  parameter int COL_W             = 10,
  parameter int DEFAULT_THRESHOLD = 35
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_y,
  input  logic [DATA_W+2:0] cfg_threshold,
  input  logic              cfg_mode,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic              post_img_bit,
  output logic [DATA_W-1:0] post_img_y,
  output logic              line_overflow
);

  // Stream qualifiers: a pixel transfers on a clk edge where href and clken are both
  // high; there is no backpressure, so the sink must accept every qualified pixel.
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW = DATA_W + 2;
  localparam int MW = DATA_W + 3;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W);
  localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
  localparam logic [MW-1:0]    THR_RST = MW'(DEFAULT_THRESHOLD);
  localparam logic [MW-1:0]    PIX_MAX = MW'((1 << DATA_W) - 1);

  logic              vsync_q, href_q;
  logic [COL_W-1:0]  col_q, col_d, row_q, row_d;
  logic [MW-1:0]     thr_q, thr_d;
  logic              mode_q, mode_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        vs_sr_q, vs_sr_d, hs_sr_q, hs_sr_d, ce_sr_q, ce_sr_d;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb2_q [IMG_W];
  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [SW-1:0]     sl_q, sl_d, sr_q, sr_d, st_q, st_d, sb_q, sb_d;
  logic [SW-1:0]     gx_q, gx_d, gy_q, gy_d;
  logic              bit_q, bit_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [MW-1:0]     mag;
  logic              vsync_rise, href_fall, pix_en, col_ovf, lb_we;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] lb1_rd, lb2_rd;

  function automatic logic [SW-1:0] wsum(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  // Compare first so the unsigned subtraction can never wrap.
  function automatic logic [SW-1:0] absdiff(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign vsync_rise = per_frame_vsync & ~vsync_q;
  assign href_fall  = ~per_frame_href & href_q;
  assign pix_en     = per_frame_href & per_frame_clken;
  assign col_ovf    = (col_q >= COL_MAX);
  assign lb_we      = pix_en & ~col_ovf;
  assign rd_addr    = col_q[AW-1:0];
  assign lb1_rd     = lb1_q[rd_addr];
  assign lb2_rd     = lb2_q[rd_addr];

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    thr_d  = thr_q;
    mode_d = mode_q;
    ovf_d  = ovf_q;
    if (href_fall)           col_d = '0;
    else if (lb_we)          col_d = col_q + 1'b1;
    if (vsync_rise)          row_d = '0;
    else if (href_fall && row_q != '1) row_d = row_q + 1'b1;
    if (vsync_rise) begin
      thr_d  = cfg_threshold;
      mode_d = cfg_mode;
      ovf_d  = 1'b0;
    end
    if (pix_en && col_ovf)   ovf_d = 1'b1;
    vs_sr_d = {vs_sr_q[2:0], per_frame_vsync};
    hs_sr_d = {hs_sr_q[2:0], per_frame_href};
    ce_sr_d = {ce_sr_q[2:0], per_frame_clken};
  end

  // Window rows: 0 = line r-2, 1 = line r-1, 2 = current line; column 2 is newest.
  always_comb begin
    win_d = win_q;
    if (pix_en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = per_img_y;
    end
  end

  always_comb begin
    v1_d = per_frame_href && (row_q >= COL_TWO) && (col_q >= COL_TWO) && !col_ovf;
    v2_d = v1_q;
    v3_d = v2_q;
    sl_d = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
    sr_d = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
    st_d = wsum(win_q[0][0], win_q[0][1], win_q[0][2]);
    sb_d = wsum(win_q[2][0], win_q[2][1], win_q[2][2]);
    gx_d = absdiff(sr_q, sl_q);
    gy_d = absdiff(st_q, sb_q);
    mag  = MW'(gx_q) + MW'(gy_q);
    bit_d = 1'b0;
    y_d   = '0;
    if (v3_q && hs_sr_q[2]) begin
      bit_d = (mag >= thr_q);
      if (mode_q) y_d = (mag > PIX_MAX) ? PIX_MAX[DATA_W-1:0] : mag[DATA_W-1:0];
      else        y_d = {DATA_W{bit_d}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      thr_q   <= THR_RST;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vs_sr_q <= '0;
      hs_sr_q <= '0;
      ce_sr_q <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      sl_q  <= '0;
      sr_q  <= '0;
      st_q  <= '0;
      sb_q  <= '0;
      gx_q  <= '0;
      gy_q  <= '0;
      bit_q <= 1'b0;
      y_q   <= '0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      col_q   <= col_d;
      row_q   <= row_d;
      thr_q   <= thr_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      vs_sr_q <= vs_sr_d;
      hs_sr_q <= hs_sr_d;
      ce_sr_q <= ce_sr_d;
      win_q   <= win_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      sl_q  <= sl_d;
      sr_q  <= sr_d;
      st_q  <= st_d;
      sb_q  <= sb_d;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      bit_q <= bit_d;
      y_q   <= y_d;
    end
  end

  // Line buffers are plain RAM: read-before-write, no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb1_q[rd_addr] <= per_img_y;
      lb2_q[rd_addr] <= lb1_rd;
    end
  end

  assign post_frame_vsync = vs_sr_q[3];
  assign post_frame_href  = hs_sr_q[3];
  assign post_frame_clken = ce_sr_q[3];
  assign post_img_bit     = bit_q;
  assign post_img_y       = y_q;
  assign line_overflow    = ovf_q;

endmodule

// File: tb/tb_vip_sobel_edge_param.sv
// Directed bench for vip_sobel_edge_param: step/flat frames with hand-derived
// edge positions, threshold/mode latching, line overflow and mid-frame reset.
module tb_vip_sobel_edge_param;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 16;
  localparam int COL_W  = 5;

  logic              clk;
  logic              rst_n;
  logic              per_frame_vsync, per_frame_href, per_frame_clken;
  logic [DATA_W-1:0] per_img_y;
  logic [DATA_W+2:0] cfg_threshold;
  logic              cfg_mode;
  logic              post_frame_vsync, post_frame_href, post_frame_clken;
  logic              post_img_bit;
  logic [DATA_W-1:0] post_img_y;
  logic              line_overflow;

  vip_sobel_edge_param #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .COL_W(COL_W), .DEFAULT_THRESHOLD(35)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_bit(post_img_bit),
    .post_img_y(post_img_y), .line_overflow(line_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {vsync, href, clken, bit, y} expected 4 clk after being driven
  logic [11:0] exp_q[$];
  int  n_vec;
  int  n_err;
  logic ovf_exp;
  logic last_vs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic prefill();
    exp_q.delete();
    repeat (4) exp_q.push_back(12'h000);
    ovf_exp = 1'b0;
    last_vs = 1'b0;
  endtask

  // driver: one clk cycle of input, checking the output that is due now
  task automatic drive_cycle(input logic vs, input logic hs, input logic ce,
                             input logic [7:0] y, input logic eb, input logic [7:0] ey,
                             input int col);
    logic [11:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    check("pipe", {20'd0, post_frame_vsync, post_frame_href, post_frame_clken,
                   post_img_bit, post_img_y}, {20'd0, e});
    check("ovf", {31'd0, line_overflow}, {31'd0, ovf_exp});
    per_frame_vsync = vs;
    per_frame_href  = hs;
    per_frame_clken = ce;
    per_img_y       = y;
    exp_q.push_back({vs, hs, ce, eb, ey});
    if (vs && !last_vs) ovf_exp = 1'b0;
    if (hs && ce && col >= IMG_W) ovf_exp = 1'b1;
    last_vs = vs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0);
  endtask

  // kind 0 flat 0x80, 1 vertical step at col 5, 2 horizontal step at row 4
  function automatic logic [7:0] pix(input int kind, input int amp, input int r, input int c);
    if (kind == 1) return (c >= 5) ? 8'(amp) : 8'h00;
    if (kind == 2) return (r >= 4) ? 8'(amp) : 8'h00;
    return 8'h80;
  endfunction

  // Hand-derived: vertical step gives |Gx|=4*amp only at cols 5,6;
  // horizontal step gives |Gy|=4*amp only at rows 4,5; everything else is 0.
  function automatic logic [8:0] exp_out(input int kind, input int amp, input int r,
                                         input int c, input int thr, input logic mode);
    int mag;
    logic b;
    logic [7:0] y;
    if (r < 2 || c < 2 || c >= IMG_W) return 9'h000;
    mag = 0;
    if (kind == 1 && (c == 5 || c == 6)) mag = 4 * amp;
    if (kind == 2 && (r == 4 || r == 5)) mag = 4 * amp;
    b = (mag >= thr);
    if (mode) y = (mag > 255) ? 8'hFF : 8'(mag);
    else      y = b ? 8'hFF : 8'h00;
    return {b, y};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_y       = '0;
    #1;
    check("rst_out", {26'd0, post_frame_vsync, post_frame_href, post_frame_clken,
                      post_img_bit, line_overflow, |post_img_y}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prefill();
  endtask

  task automatic drive_frame(input int kind, input int amp, input int rows, input int cols,
                             input int cfg_thr, input logic cfg_md, input int exp_thr,
                             input logic exp_md, input int mid_thr, input int rst_row,
                             input logic with_vs);
    logic [8:0] eo;
    cfg_threshold = 11'(cfg_thr);
    cfg_mode      = cfg_md;
    if (with_vs) begin
      repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0);
      idle(2);
    end else begin
      idle(2);
    end
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (r == rst_row && c == 4) begin
          do_reset();
          return;
        end
        if (r == 3 && c == 0 && mid_thr >= 0) begin
          cfg_threshold = 11'(mid_thr);
          cfg_mode      = ~cfg_md;
        end
        eo = exp_out(kind, amp, r, c, exp_thr, exp_md);
        drive_cycle(1'b0, 1'b1, 1'b1, pix(kind, amp, r, c), eo[8], eo[7:0], c);
      end
      idle(3);
    end
    idle(2);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_y       = '0;
    cfg_threshold   = '0;
    cfg_mode        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {26'd0, post_frame_vsync, post_frame_href, post_frame_clken,
                    post_img_bit, line_overflow, |post_img_y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prefill();

    // flat 0x80: no edges, sync lines delayed by 4
    drive_frame(0, 0, 8, 8, 35, 1'b0, 35, 1'b0, -1, -1, 1'b1);
    // vertical step 0->100, binary mode
    drive_frame(1, 100, 8, 8, 35, 1'b0, 35, 1'b0, -1, -1, 1'b1);
    // same step in magnitude mode: 400 saturates to 255
    drive_frame(1, 100, 8, 8, 35, 1'b1, 35, 1'b1, -1, -1, 1'b1);
    // horizontal step 0->10 in magnitude mode: Gy=40
    drive_frame(2, 10, 8, 8, 35, 1'b1, 35, 1'b1, -1, -1, 1'b1);
    // 20-pixel lines overflow a 16-deep line buffer
    drive_frame(1, 100, 8, 20, 35, 1'b0, 35, 1'b0, -1, -1, 1'b1);
    // Gx=32 below 35; mid-frame change to 32 (and mode flip) must not apply yet
    drive_frame(1, 8, 8, 8, 35, 1'b0, 35, 1'b0, 32, -1, 1'b1);
    // next frame latches 32: equality counts as an edge
    drive_frame(1, 8, 8, 8, 32, 1'b0, 32, 1'b0, -1, -1, 1'b1);
    // reset mid-line with threshold 32 latched
    drive_frame(1, 100, 8, 8, 32, 1'b0, 32, 1'b0, -1, 3, 1'b1);
    // no vsync after reset: shadow threshold must be back to 35 despite cfg=32
    drive_frame(1, 8, 8, 8, 32, 1'b0, 35, 1'b0, -1, -1, 1'b0);
    // full frame after reset reproduces the step result
    drive_frame(1, 100, 8, 8, 35, 1'b0, 35, 1'b0, -1, -1, 1'b1);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
